// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants, width helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_TICK   = 7;

    // Number of bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a configurable reset value.
module uart_sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic sync_o
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta   <= RESET_VAL;
            sync_o <= RESET_VAL;
        end else begin
            meta   <= async_i;
            sync_o <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver: 16x oversampled, LSB-first frame with start-bit validation and framing-error flag.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int unsigned D_BITS  = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              s_tick_i,
    input  logic              rx_data_i,
    output logic [D_BITS-1:0] rx_data_o,
    output logic              rx_done_o,
    output logic              frame_err_o
);

    localparam int unsigned TICK_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int unsigned TICK_W   = cnt_width(TICK_MAX - 1);
    localparam int unsigned BIT_W    = cnt_width(D_BITS - 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(MID_TICK);
    localparam logic [TICK_W-1:0] TICK_BIT  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_STOP = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(D_BITS - 1);

    uart_state_e        state;
    logic [TICK_W-1:0]  tick_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [D_BITS-1:0]  shift_reg;
    logic               rx_s;
    logic               rx_prev;

    uart_sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (rx_data_i),
        .sync_o  (rx_s)
    );

    // Previous synchronised level, used to detect the start-bit falling edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_prev <= 1'b1;
        end else begin
            rx_prev <= rx_s;
        end
    end

    // Receive FSM: start validation at mid-bit, mid-bit data sampling, stop check, registered strobes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            rx_data_o   <= '0;
            rx_done_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            rx_done_o   <= 1'b0;
            frame_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    // Only a high-to-low transition starts a frame; a held-low line is ignored.
                    if (rx_prev && !rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: begin
                    if (s_tick_i) begin
                        if (tick_cnt == TICK_MID) begin
                            if (!rx_s) begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (s_tick_i) begin
                        if (tick_cnt == TICK_BIT) begin
                            tick_cnt  <= '0;
                            shift_reg <= {rx_s, shift_reg[D_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BIT_W'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                STOP: begin
                    if (s_tick_i) begin
                        if (tick_cnt == TICK_STOP) begin
                            state <= IDLE;
                            if (rx_s) begin
                                rx_data_o <= shift_reg;
                                rx_done_o <= 1'b1;
                            end else begin
                                frame_err_o <= 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: tick-aligned frame driver, strobe monitor and frame-level reference model.
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       rx0;
    logic       rx1;
    logic [7:0] data0;
    logic       done0;
    logic       err0;
    logic [6:0] data1;
    logic       done1;
    logic       err1;

    uart_rx_fsm #(.D_BITS(8), .SB_TICK(16)) dut0 (
        .clk_i       (clk),
        .reset_i     (reset),
        .s_tick_i    (s_tick),
        .rx_data_i   (rx0),
        .rx_data_o   (data0),
        .rx_done_o   (done0),
        .frame_err_o (err0)
    );

    uart_rx_fsm #(.D_BITS(7), .SB_TICK(32)) dut1 (
        .clk_i       (clk),
        .reset_i     (reset),
        .s_tick_i    (s_tick),
        .rx_data_i   (rx1),
        .rx_data_o   (data1),
        .rx_done_o   (done1),
        .frame_err_o (err1)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         tick;
    } evt_t;

    evt_t       got0[$];
    evt_t       got1[$];
    evt_t       exp0[$];
    evt_t       exp1[$];
    logic [7:0] last_good [2];
    int         n_cmp    = 0;
    int         n_err    = 0;
    int         tick_cnt = 0;
    logic       prev0    = 1'b0;
    logic       prev1    = 1'b0;

    always #5 clk = ~clk;

    // One-clk tick every 4 clocks, changed on the falling edge.
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    always @(posedge clk) if (s_tick) tick_cnt <= tick_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe monitor: records every strobe with the tick count at which it appears.
    always @(posedge clk) begin
        evt_t e;
        #1;
        if (done0 || err0) begin
            check("dut0_excl", 32'(done0 & err0), 32'd0);
            check("dut0_width", 32'(prev0), 32'd0);
            e.is_err = err0; e.data = data0; e.tick = tick_cnt;
            got0.push_back(e);
        end
        if (done1 || err1) begin
            check("dut1_excl", 32'(done1 & err1), 32'd0);
            check("dut1_width", 32'(prev1), 32'd0);
            e.is_err = err1; e.data = {1'b0, data1}; e.tick = tick_cnt;
            got1.push_back(e);
        end
        prev0 = done0 | err0;
        prev1 = done1 | err1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Waits for n tick-sampling clock edges, then steps just past the edge.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!s_tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic drive(input int sel, input logic v);
        if (sel == 1) rx1 = v;
        else          rx0 = v;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_data0", 32'(data0), 32'd0);
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_err0",  32'(err0),  32'd0);
        check("rst_data1", 32'(data1), 32'd0);
        reset = 1'b0;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
    endtask

    // Sends one frame (16 ticks per bit) and records the outcome the receiver must report.
    task automatic send_frame(input int sel, input logic [7:0] data, input bit stop_ok,
                              input int extra_low, input int rst_bit);
        int   nb;
        int   sb;
        int   t0;
        bit   aborted;
        evt_t e;
        nb = (sel == 1) ? 7 : 8;
        sb = (sel == 1) ? 32 : 16;
        aborted = 1'b0;
        drive(sel, 1'b0);
        t0 = tick_cnt;
        wait_ticks(16);
        for (int i = 0; i < nb; i++) begin
            drive(sel, data[i]);
            if (i == rst_bit) begin
                wait_ticks(8);
                pulse_reset();
                aborted = 1'b1;
                wait_ticks(8);
            end else begin
                wait_ticks(16);
            end
        end
        drive(sel, stop_ok);
        wait_ticks(sb + extra_low);
        drive(sel, 1'b1);
        if (!aborted) begin
            e.tick = t0 + 16 * (1 + nb) + sb - 8;
            e.is_err = !stop_ok;
            if (stop_ok) begin
                e.data = data & (8'hFF >> (8 - nb));
                last_good[sel] = e.data;
            end else begin
                e.data = last_good[sel];
            end
            if (sel == 1) exp1.push_back(e);
            else          exp0.push_back(e);
        end
    endtask

    task automatic compare(input string name, input evt_t got[$], input evt_t exp[$]);
        check({name, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            check({name, "_kind"}, 32'(got[i].is_err), 32'(exp[i].is_err));
            check({name, "_data"}, 32'(got[i].data),   32'(exp[i].data));
            check({name, "_tick"}, 32'(got[i].tick),   32'(exp[i].tick));
        end
    endtask

    task automatic flush0(input string name);
        compare(name, got0, exp0);
        got0.delete();
        exp0.delete();
    endtask

    task automatic flush1(input string name);
        compare(name, got1, exp1);
        got1.delete();
        exp1.delete();
    endtask

    initial begin
        int         sel;
        logic [7:0] d;
        bit         ok;
        reset = 1'b1;
        rx0   = 1'b1;
        rx1   = 1'b1;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_data0", 32'(data0), 32'd0);
        check("reset_done0", 32'(done0), 32'd0);
        check("reset_err0",  32'(err0),  32'd0);
        check("reset_data1", 32'(data1), 32'd0);
        check("reset_done1", 32'(done1), 32'd0);
        check("reset_err1",  32'(err1),  32'd0);
        reset = 1'b0;
        wait_ticks(4);

        send_frame(0, 8'hA5, 1'b1, 0, -1);
        wait_ticks(10);
        flush0("a5");

        send_frame(0, 8'h3C, 1'b1, 0, -1);
        send_frame(0, 8'hC3, 1'b1, 0, -1);
        wait_ticks(10);
        flush0("b2b");

        drive(0, 1'b0);
        wait_ticks(3);
        drive(0, 1'b1);
        wait_ticks(20);
        flush0("glitch");
        send_frame(0, 8'h55, 1'b1, 0, -1);
        wait_ticks(10);
        flush0("after_glitch");

        send_frame(0, 8'h81, 1'b0, 40, -1);
        wait_ticks(16);
        flush0("ferr_break");
        check("ferr_hold", 32'(data0), 32'h55);

        send_frame(0, 8'hFF, 1'b1, 0, 4);
        wait_ticks(16);
        flush0("mid_reset");
        send_frame(0, 8'h12, 1'b1, 0, -1);
        wait_ticks(10);
        flush0("after_reset");

        send_frame(1, 8'h5A, 1'b1, 0, -1);
        wait_ticks(10);
        flush1("d7_5a");

        for (int n = 0; n < 36; n++) begin
            sel = ($urandom_range(0, 3) == 0) ? 1 : 0;
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 4) != 0);
            send_frame(sel, d, ok, ok ? 0 : int'($urandom_range(0, 20)), -1);
            wait_ticks(ok ? int'($urandom_range(0, 12)) : int'($urandom_range(1, 12)));
        end
        wait_ticks(40);
        flush0("rand0");
        flush1("rand1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
